// File: rtl/riscv_pkg.sv
// Shared core types: register width, register address and regfile FSM states.
package riscv_pkg;
    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [REG_AW-1:0] regaddr_t;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_t;
endpackage

// File: rtl/wb_mux.sv
// Write-back source select; also usable by the EX forwarding unit.
module wb_mux
    import riscv_pkg::*;
(
    input  logic  sel,
    input  xlen_t alu_result,
    input  xlen_t mem_data,
    output xlen_t wb_data
);
    assign wb_data = sel ? mem_data : alu_result;
endmodule

// File: rtl/writeback_regfile.sv
// MEM/WB consumer: write-back select, 32x64 register file with post-reset
// clear sequencer, and two combinational read ports with WB-to-ID bypass.
module writeback_regfile
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        actMemtoReg,
    input  logic        actRegWrite,
    input  regaddr_t    actAddRegWrite,
    input  xlen_t       actResultAlu,
    input  xlen_t       actDataMem,
    input  regaddr_t    readAdd1,
    input  regaddr_t    readAdd2,
    output xlen_t       readData1,
    output xlen_t       readData2,
    output xlen_t       writeDataWB,
    output logic        ready,
    output logic [31:0] wbCount
);
    rf_state_t   state;
    regaddr_t    clr_idx;
    logic [31:0] wb_cnt;
    xlen_t       rf [NREGS];

    logic        commit;
    logic        arr_we;
    regaddr_t    arr_addr;
    xlen_t       arr_data;

    wb_mux u_wb_mux (
        .sel        (actMemtoReg),
        .alu_result (actResultAlu),
        .mem_data   (actDataMem),
        .wb_data    (writeDataWB)
    );

    assign ready   = (state == RF_RUN);
    assign wbCount = wb_cnt;
    // x0 writes are dropped entirely, so they never count as commits.
    assign commit  = ready && actRegWrite && (actAddRegWrite != '0);

    // Single array write port shared by the clear sequencer and commits.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = '0;
        arr_data = '0;
        if (!reset) begin
            if (state == RF_INIT) begin
                arr_we   = 1'b1;
                arr_addr = clr_idx;
            end else if (commit) begin
                arr_we   = 1'b1;
                arr_addr = actAddRegWrite;
                arr_data = writeDataWB;
            end
        end
    end

    // Register array storage (no reset; contents owned by the clear sequence).
    always_ff @(posedge clk) begin
        if (arr_we)
            rf[arr_addr] <= arr_data;
    end

    // FSM, clear counter and commit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RF_INIT;
            clr_idx <= '0;
            wb_cnt  <= '0;
        end else begin
            case (state)
                RF_INIT: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == regaddr_t'(NREGS - 1))
                        state <= RF_RUN;
                end
                RF_RUN: begin
                    if (commit)
                        wb_cnt <= wb_cnt + 32'd1;
                end
                default: state <= RF_INIT;
            endcase
        end
    end

    // Read port 1: x0 and not-ready force zero, bypass wins over the array.
    always_comb begin
        readData1 = '0;
        if (ready && readAdd1 != '0) begin
            if (actRegWrite && actAddRegWrite == readAdd1)
                readData1 = writeDataWB;
            else
                readData1 = rf[readAdd1];
        end
    end

    // Read port 2: same resolution as port 1, independently.
    always_comb begin
        readData2 = '0;
        if (ready && readAdd2 != '0) begin
            if (actRegWrite && actAddRegWrite == readAdd2)
                readData2 = writeDataWB;
            else
                readData2 = rf[readAdd2];
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: clear sequence, commits, bypass,
// x0 handling, INIT write suppression, reset restart and counter wrap.
module tb_writeback_regfile;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        actMemtoReg;
    logic        actRegWrite;
    regaddr_t    actAddRegWrite;
    xlen_t       actResultAlu;
    xlen_t       actDataMem;
    regaddr_t    readAdd1;
    regaddr_t    readAdd2;
    xlen_t       readData1;
    xlen_t       readData2;
    xlen_t       writeDataWB;
    logic        ready;
    logic [31:0] wbCount;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .actMemtoReg    (actMemtoReg),
        .actRegWrite    (actRegWrite),
        .actAddRegWrite (actAddRegWrite),
        .actResultAlu   (actResultAlu),
        .actDataMem     (actDataMem),
        .readAdd1       (readAdd1),
        .readAdd2       (readAdd2),
        .readData1      (readData1),
        .readData2      (readData2),
        .writeDataWB    (writeDataWB),
        .ready          (ready),
        .wbCount        (wbCount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic m2r, input regaddr_t a, input xlen_t alu, input xlen_t mem);
        actRegWrite    = 1'b1;
        actMemtoReg    = m2r;
        actAddRegWrite = a;
        actResultAlu   = alu;
        actDataMem     = mem;
    endtask

    // Counts negedges after reset release until ready rises (bounded).
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n), 64'd32);
    endtask

    initial begin
        reset = 1'b1;
        actMemtoReg = 0; actRegWrite = 0; actAddRegWrite = '0;
        actResultAlu = '0; actDataMem = '0; readAdd1 = '0; readAdd2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_wbcnt", wbCount, 0);
        actMemtoReg = 1; actDataMem = 64'hCAFE; actResultAlu = 64'hBEEF;
        #1 chk("rst_mux", writeDataWB, 64'hCAFE);
        actMemtoReg = 0; actDataMem = '0; actResultAlu = '0;

        // Release; ready must stay low before each of the 32 clear edges.
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            if (e == 10) begin
                wr(0, 5'd3, 64'hAA, 64'h0);
                readAdd1 = 5'd3;
                #1 chk("init_rd_bypass", readData1, 0);
            end
            #1 chk($sformatf("init_ready_%0d", e), ready, 0);
            @(negedge clk);
            actRegWrite = 0;
        end
        chk("ready_after_32", ready, 1);
        chk("init_wbcnt", wbCount, 0);
        readAdd1 = 5'd3;
        #1 chk("init_write_ignored", readData1, 0);
        for (int i = 1; i < 32; i++) begin
            readAdd1 = regaddr_t'(i);
            readAdd2 = regaddr_t'(32 - i);
            #1 chk($sformatf("clr_rd1_%0d", i), readData1, 0);
            chk($sformatf("clr_rd2_%0d", 32 - i), readData2, 0);
        end

        // ALU write with same-cycle bypass, then array read.
        wr(0, 5'd5, 64'h1234, 64'hDEAD);
        readAdd1 = 5'd5;
        #1 chk("wd_alu", writeDataWB, 64'h1234);
        chk("bypass_x5", readData1, 64'h1234);
        @(negedge clk);
        actRegWrite = 0;
        #1 chk("array_x5", readData1, 64'h1234);
        chk("wbcnt_1", wbCount, 1);

        // Memory write-back source.
        wr(1, 5'd7, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF);
        #1 chk("wd_mem", writeDataWB, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        actRegWrite = 0;
        readAdd2 = 5'd7;
        #1 chk("array_x7", readData2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x5_kept", readData1, 64'h1234);
        chk("wbcnt_2", wbCount, 2);

        // x0 write dropped and not counted.
        wr(0, 5'd0, 64'h55, 64'h0);
        readAdd1 = 5'd0;
        #1 chk("x0_bypass", readData1, 0);
        @(negedge clk);
        actRegWrite = 0;
        #1 chk("x0_array", readData1, 0);
        chk("wbcnt_x0", wbCount, 2);

        // Both ports bypassing the same register; other port from array.
        wr(0, 5'd12, 64'h99, 64'h0);
        readAdd1 = 5'd12; readAdd2 = 5'd12;
        #1 chk("dual_bypass1", readData1, 64'h99);
        chk("dual_bypass2", readData2, 64'h99);
        readAdd2 = 5'd5;
        #1 chk("p2_array_during_wr", readData2, 64'h1234);
        @(negedge clk);
        actRegWrite = 0;
        readAdd2 = 5'd12;
        #1 chk("array_x12", readData2, 64'h99);
        chk("wbcnt_3", wbCount, 3);

        // Counter wrap from 2^32-1.
        force dut.wb_cnt = 32'hFFFF_FFFF;
        #1 release dut.wb_cnt;
        #1 chk("wbcnt_preload", wbCount, 32'hFFFF_FFFF);
        wr(0, 5'd13, 64'h42, 64'h0);
        @(negedge clk);
        actRegWrite = 0;
        readAdd1 = 5'd13;
        #1 chk("wbcnt_wrap", wbCount, 0);
        chk("array_x13", readData1, 64'h42);

        // Reset in RUN restarts the clear.
        wr(0, 5'd9, 64'h77, 64'h0);
        @(negedge clk);
        actRegWrite = 0;
        readAdd1 = 5'd9;
        #1 chk("array_x9", readData1, 64'h77);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_run_ready", ready, 0);
        chk("rst_run_rd", readData1, 0);
        chk("rst_run_wbcnt", wbCount, 0);
        reset = 1'b0;
        wait_ready("run_rst_latency");
        #1 chk("x9_cleared", readData1, 0);

        // Reset mid-INIT restarts the full 32-edge clear.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready("init_rst_latency");
        readAdd1 = 5'd5;
        #1 chk("x5_cleared", readData1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the MEM/WB outputs (actMemtoReg, actRegWrite, actAddRegWrite, actResultAlu, actDataMem) and does three things:
  - selects the write-back value;
  - commits it to a 32x64 integer register file;
  - serves two combinational read ports to the decode stage, with a same-cycle WB-to-ID bypass.
- After reset, a clear sequencer zeroes the register array before the core may issue.

Parameters:
- XLEN, 64, data width of registers and write-back path.
- NREGS, 32, number of architectural registers; address width is clog2(NREGS) = 5.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- actMemtoReg  in  1  write-back source select: 1 = memory data, 0 = ALU result.
- actRegWrite  in  1  write-back enable.
- actAddRegWrite  in  5  destination register address.
- actResultAlu  in  XLEN  ALU result from MEM/WB.
- actDataMem  in  XLEN  load data from MEM/WB.
- readAdd1  in  5  read port 1 address (rs1).
- readAdd2  in  5  read port 2 address (rs2).
- readData1  out  XLEN  read port 1 data.
- readData2  out  XLEN  read port 2 data.
- writeDataWB  out  XLEN  selected write-back value, exported for EX forwarding.
- ready  out  1  high when the clear sequence is complete and the file is in normal operation.
- wbCount  out  32  number of committed register writes.

Behaviour:
- Write-back mux (combinational): writeDataWB = actMemtoReg ? actDataMem : actResultAlu. It is valid in every state, including during reset.
- FSM has two states, INIT and RUN, plus a 5-bit clear counter clrIdx.
- While reset is high:
  - state <= INIT, clrIdx <= 0, wbCount <= 0.
  - The array is not modified during reset cycles.
- INIT:
  - Each rising edge with reset low writes 0 to reg[clrIdx] and increments clrIdx.
  - The edge that clears reg[31] (clrIdx = 31) moves the FSM to RUN; clrIdx wraps to 0.
  - Result: ready rises exactly 32 edges after reset deasserts.
- ready = (state == RUN). It is combinational from state, so ready = 0 during reset and throughout INIT.
- In INIT:
  - readData1 and readData2 = 0.
  - MEM/WB writes are ignored, and wbCount does not increment.
- RUN, commit: at the rising edge, if actRegWrite && actAddRegWrite != 0, then reg[actAddRegWrite] <= writeDataWB and wbCount <= wbCount + 1.
- wbCount wraps modulo 2^32. Writes to x0 are dropped and do not count.
- RUN, read port n (combinational):
  - If readAddn == 0, output 0.
  - Else if actRegWrite && actAddRegWrite == readAddn, output writeDataWB (bypass; the new value is visible in the same cycle as the commit).
  - Else output reg[readAddn].
- Both read ports may hit the same address, or the bypass, simultaneously; each port resolves independently.
- Reset asserted mid-INIT or mid-RUN: the next edge returns to INIT with clrIdx = 0, and the full 32-cycle clear restarts. Register contents are undefined until the clear completes, but reads are forced to 0 while not ready.
- x0 reads as 0 in all states. reg[0] is cleared in INIT but never written in RUN.

Decomposition:
- Shared package riscv_pkg:
  - XLEN = 64, REG_AW = 5, NREGS = 32.
  - typedef logic [XLEN-1:0] xlen_t.
  - typedef logic [REG_AW-1:0] regaddr_t.
  - typedef enum logic {RF_INIT, RF_RUN} rf_state_t.
- Optional sub-module wb_mux: the combinational 2:1 write-back select, reusable by the EX forwarding unit. Array, FSM and read logic stay in writeback_regfile.

Test Plan:
- Reset for 2 cycles, then release → ready = 0 for 32 edges and 1 after the 32nd; all 31 of readAdd1 = 1..31 read 0; wbCount = 0.
- In RUN, actRegWrite = 1, actMemtoReg = 0, actAddRegWrite = 5, actResultAlu = 64'h1234, actDataMem = 64'hDEAD; readAdd1 = 5 in the same cycle → readData1 = 64'h1234 via bypass; after the edge, with actRegWrite = 0, readData1 = 64'h1234 from the array; wbCount = 1.
- actMemtoReg = 1, actAddRegWrite = 7, actDataMem = 64'hFFFF_FFFF_FFFF_FFFF → writeDataWB = all ones; readAdd2 = 7 after the edge → all ones.
- Write to x0 with actResultAlu = 64'h55 → readData1 at readAdd1 = 0 stays 0; wbCount unchanged.
- Write during INIT (cycle 10 after reset) to x3 = 64'hAA → ignored; after ready, x3 reads 0 and wbCount = 0.
- Write x9 = 64'h77 in RUN, assert reset for 1 cycle → ready drops; 32 edges later x9 reads 0.
- Preload wbCount to 2^32-1 via forced state or a long run; one more commit → wbCount = 0.
